divider_seq_param: RTL and testbench

- Parametrised sequential restoring divider; successor to the fixed 16-bit unsigned board divider.
- Adds operand ports, per-operation signed/unsigned mode, divide-by-zero and overflow flags, and a busy/done handshake.
- Sits between operand sources (switch/register front end) and the display/LED driver, which consumes quotient/remainder on done.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_sign_conv.sv | 16 +
 rtl/divider_seq_param.sv | 164 ++++++++++++++++
 tb/tb_divider_seq_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding used by divider_seq_param.
package div_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_sign_conv.sv
// Conditional two's-complement negate, WIDTH bits wide.
// Used for operand magnitudes and for the final sign fix.
module div_sign_conv #(
    parameter int WIDTH = 16
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Negate when requested; MIN maps onto itself as unsigned.
    always_comb begin
        y = neg ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
    end

endmodule

// File: rtl/divider_seq_param.sv
// Parametrised sequential restoring divider, signed/unsigned.
// Optional macro DIV_ABORT_EN: start while busy restarts the op.
module divider_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_w;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic             smode;
    logic             qsign;
    logic             rsign;
    logic             dz;
    logic             ov_p;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             accept;

    div_sign_conv #(.WIDTH(WIDTH)) u_abs_dvd (
        .neg (signed_mode & dividend[WIDTH-1]),
        .a   (dividend),
        .y   (dvd_abs)
    );

    div_sign_conv #(.WIDTH(WIDTH)) u_abs_dvs (
        .neg (signed_mode & divisor[WIDTH-1]),
        .a   (divisor),
        .y   (dvs_abs)
    );

    div_sign_conv #(.WIDTH(WIDTH)) u_fix_quo (
        .neg (smode & qsign),
        .a   (quo_w),
        .y   (q_fix)
    );

    div_sign_conv #(.WIDTH(WIDTH)) u_fix_rem (
        .neg (smode & rsign),
        .a   (rem_w),
        .y   (r_fix)
    );

    // One restoring step: shift in next dividend bit, trial subtract.
    always_comb begin
        rem_sh = {rem_w, quo_w[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
    end

    // A new start is taken in IDLE/DONE, or anywhere when aborting.
`ifdef DIV_ABORT_EN
    assign accept = start;
`else
    assign accept = start && (state == IDLE || state == DONE);
`endif

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_w     <= '0;
            quo_w     <= '0;
            dvs       <= '0;
            dvd_raw   <= '0;
            smode     <= 1'b0;
            qsign     <= 1'b0;
            rsign     <= 1'b0;
            dz        <= 1'b0;
            ov_p      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state   <= BUSY;
                cnt     <= CNT_W'(WIDTH);
                smode   <= signed_mode;
                qsign   <= signed_mode
                           & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                rsign   <= signed_mode & dividend[WIDTH-1];
                quo_w   <= dvd_abs;
                rem_w   <= '0;
                dvs     <= dvs_abs;
                dvd_raw <= dividend;
                dz      <= (divisor == '0);
                ov_p    <= signed_mode && (dividend == MIN)
                           && (divisor == '1);
                dbz     <= 1'b0;
                ovf     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    BUSY: begin
                        if (dz) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            quotient  <= '1;
                            remainder <= dvd_raw;
                            dbz       <= 1'b1;
                        end else if (cnt != '0) begin
                            busy <= 1'b1;
                            cnt  <= cnt - 1'b1;
                            if (!trial[WIDTH]) begin
                                rem_w <= trial[WIDTH-1:0];
                                quo_w <= {quo_w[WIDTH-2:0], 1'b1};
                            end else begin
                                rem_w <= rem_sh[WIDTH-1:0];
                                quo_w <= {quo_w[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            busy  <= 1'b1;
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        quotient  <= q_fix;
                        remainder <= r_fix;
                        ovf       <= ov_p;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider_seq_param.sv
// Scoreboard bench for divider_seq_param (WIDTH=16).
// Driver queues expected results; monitor checks on done.
module tb_divider_seq_param;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
    logic         ovf;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
        int           bsy;
        int           sedge;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   ncmp;
    int   nerr;
    int   cyc;
    int   bcnt;

    divider_seq_param #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .dbz         (dbz),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act,
                       input longint req);
        ncmp++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: count busy cycles, compare results on done.
    always @(negedge clk) begin
        if (rst && busy) bcnt++;
        if (rst && done) begin
            if (sb.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_done: got done=1, expected 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_quo"}, longint'(quotient), longint'(e.q));
                chk({e.name, "_rem"}, longint'(remainder), longint'(e.r));
                chk({e.name, "_dbz"}, longint'(dbz), longint'(e.dbz));
                chk({e.name, "_ovf"}, longint'(ovf), longint'(e.ovf));
                chk({e.name, "_lat"}, longint'(cyc - e.sedge),
                    longint'(e.lat));
                if (e.bsy >= 0)
                    chk({e.name, "_busy"}, longint'(bcnt),
                        longint'(e.bsy));
            end
            bcnt = 0;
        end
    end

    task automatic issue(input string nm, input logic sm,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic z, input logic o,
                         input int lat, input int bsy);
        exp_t e;
        @(negedge clk);
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        start       = 1'b1;
        e.q = q; e.r = r; e.dbz = z; e.ovf = o;
        e.lat = lat; e.bsy = bsy; e.sedge = cyc + 1; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 100) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (sb.size() != 0) begin
            ncmp++;
            nerr++;
            $display("FAIL %s_timeout: got no done, expected done", nm);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input string nm, input logic sm,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic z, input logic o,
                       input int lat, input int bsy);
        issue(nm, sm, a, b, q, r, z, o, lat, bsy);
        drain(nm);
    endtask

    initial begin
        ncmp = 0; nerr = 0; cyc = 0; bcnt = 0;
        start = 1'b0; signed_mode = 1'b0;
        dividend = '0; divisor = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_quo", longint'(quotient), 0);
        chk("rst_rem", longint'(remainder), 0);
        chk("rst_flags", longint'({dbz, ovf}), 0);
        rst = 1'b1;
        @(negedge clk);

        run("u100_7", 0, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 18, 17);
        run("s_n100_7", 1, 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE,
            0, 0, 18, 17);
        run("s_100_n7", 1, 16'd100, 16'hFFF9, 16'hFFF2, 16'd2,
            0, 0, 18, 17);
        run("s_n100_n7", 1, 16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE,
            0, 0, 18, 17);
        run("u_dbz", 0, 16'd1234, 16'd0, 16'hFFFF, 16'd1234,
            1, 0, 1, 0);
        run("s_dbz", 1, 16'hFB2E, 16'd0, 16'hFFFF, 16'hFB2E,
            1, 0, 1, 0);
        run("s_ovf", 1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000,
            0, 1, 18, 17);
        run("u_min", 0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000,
            0, 0, 18, 17);
        run("u_max_1", 0, 16'hFFFF, 16'd1, 16'hFFFF, 16'd0,
            0, 0, 18, 17);
        run("u7_100", 0, 16'd7, 16'd100, 16'd0, 16'd7, 0, 0, 18, 17);

        // Held results in IDLE
        repeat (3) @(negedge clk);
        chk("hold_quo", longint'(quotient), 0);
        chk("hold_rem", longint'(remainder), 7);

        // Reset in the middle of an operation
        issue("rst_mid", 0, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 18, 17);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        bcnt = 0;
        chk("mid_busy", longint'(busy), 0);
        chk("mid_done", longint'(done), 0);
        chk("mid_quo", longint'(quotient), 0);
        chk("mid_rem", longint'(remainder), 0);
        chk("mid_flags", longint'({dbz, ovf}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        run("u50_5", 0, 16'd50, 16'd5, 16'd10, 16'd0, 0, 0, 18, 17);

        // Second start during BUSY
        issue("first", 0, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0, 18, 17);
        repeat (4) @(negedge clk);
`ifdef DIV_ABORT_EN
        void'(sb.pop_back());
        issue("abort", 0, 16'd20, 16'd3, 16'd6, 16'd2, 0, 0, 18, -1);
`else
        @(negedge clk);
        start = 1'b1;
        dividend = 16'd20;
        divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
`endif
        drain("second");
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
